vx_branch_resolve: RTL and testbench
====================================

Name: vx_branch_resolve

Overview:
- Receive side of the ALU branch-control interface.
- Per-warp branch tracker between the ALU blocks and the warp scheduler:
  - marks a warp stalled when a branch is issued;
  - captures the taken/dest resolution from any ALU block;
  - presents one PC-redirect per cycle to the scheduler, selected round-robin.
- Absorbs the valid-only (no-ready) branch-control outputs of NUM_BLOCKS ALU blocks without loss.

Parameters:
- NUM_WARPS, 4, warps tracked; NW_WIDTH = max(1, clog2(NUM_WARPS)).
- NUM_BLOCKS, 1, ALU blocks driving branch-control ports.
- XLEN, 32, PC/dest width.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- issue_valid, in, 1: a branch for warp issue_wid was dispatched this cycle.
- issue_wid, in, NW_WIDTH: warp of the issued branch.
- br_valid, in, NUM_BLOCKS: per-block branch-control valid.
- br_wid, in, NUM_BLOCKS*NW_WIDTH: per-block resolved warp.
- br_taken, in, NUM_BLOCKS: per-block taken flag.
- br_dest, in, NUM_BLOCKS*XLEN: per-block target PC.
- redir_valid, out, 1: redirect available.
- redir_wid, out, NW_WIDTH: warp to redirect.
- redir_taken, out, 1: resolved direction.
- redir_dest, out, XLEN: resolved target.
- redir_ready, in, 1: scheduler accepts the redirect.
- stalled, out, NUM_WARPS: warp has a branch outstanding (state != IDLE).
- err, out, 1: sticky protocol-violation flag.

Behaviour:
- Per-warp state: IDLE, WAIT, READY; per-warp taken bit and XLEN dest register.
- Reset (reset low, asynchronous):
  - all warps IDLE, taken/dest cleared;
  - RR pointer = 0, err = 0;
  - stalled = 0, redir_valid = 0, redir_wid/taken/dest = 0.
- Issue:
  - issue_valid for a warp in IDLE moves it to WAIT at the next edge.
  - issue to a WAIT or READY warp is ignored and sets err.
  - Exception: a READY warp whose redirect handshakes in the same cycle may be issued; it goes to WAIT, not IDLE, and err is not set.
- Resolution:
  - For each block b with br_valid[b]: if warp br_wid[b] is WAIT, capture br_taken[b]/br_dest[b] and move to READY at the next edge.
  - Resolution for an IDLE or READY warp is ignored and sets err.
  - Two or more blocks resolving the same warp in one cycle: lowest block index wins, err set.
  - Different warps resolved in the same cycle are all captured; nothing is dropped.
  - Issue and resolution of the same IDLE warp in the same cycle: issue wins (warp -> WAIT), the resolution is an error and sets err.
- Redirect output:
  - Combinational from registered state: redir_valid = any READY.
  - Grant = first READY warp at or after the RR pointer, wrapping modulo NUM_WARPS.
  - redir_wid/taken/dest show the granted warp's registers; all are 0 when redir_valid = 0.
  - On redir_valid && redir_ready: granted warp -> IDLE (or WAIT per the issue exception); RR pointer = (grant+1) mod NUM_WARPS.
  - Without a handshake the outputs hold stable; the pointer does not move.
- Latency:
  - Resolution at cycle t -> READY and redir_valid at t+1.
  - Handshake at t -> stalled bit clears at t+1.
  - stalled rises the cycle after issue.
- Capacity: one outstanding branch per warp, so at most NUM_WARPS entries; no overflow is possible.
- Reset mid-operation discards all pending and READY entries immediately.
- err clears only on reset.

Test Plan:
- Reset low then high, no stimulus -> stalled=0000, redir_valid=0, err=0.
- issue wid2 @t0; br_valid[0], wid=2, taken=1, dest=0x80001000 @t3 -> stalled[2]=1 from t1; redir_valid=1, wid=2, taken=1, dest=0x80001000 @t4; with redir_ready=1 @t4, stalled[2]=0 @t5.
- NUM_BLOCKS=2: issue warps 1 and 3; both resolved same cycle (dest 0x100, 0x200), redir_ready held 0 two cycles, then 1 -> outputs stable while stalled; then wid1/0x100, then wid3/0x200 on consecutive cycles; err=0.
- Round-robin fairness: all four warps READY, pointer=0, redir_ready=1; re-issue and re-resolve each warp immediately after it drains -> grant order 0,1,2,3,0…, no warp granted twice before the others.
- Violations: resolution for IDLE warp 0 -> ignored, err=1 sticky; issue to WAIT warp 1 -> err stays 1, state unchanged.
- Async reset asserted mid-cycle with warps 0 and 2 READY -> redir_valid=0 and stalled=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vx_branch_resolve_if.sv
// vx_branch_resolve_if
//   Bundles the signals between the ALU blocks, the warp scheduler and the
//   per-warp branch tracker (vx_branch_resolve).
//   - issue_valid/issue_wid : branch dispatched for a warp
//   - br_valid/br_wid/br_taken/br_dest : per-block branch resolution (no ready)
//   - redir_valid/redir_wid/redir_taken/redir_dest/redir_ready : PC redirect
//   - stalled : per-warp "branch outstanding" flags
//   - err : sticky protocol-violation flag
//   modport slave  : the tracker (receives issue/resolution, drives redirect)
//   modport master : the environment (ALU blocks + scheduler)
interface vx_branch_resolve_if #(
  parameter int NUM_WARPS  = 4,
  parameter int NUM_BLOCKS = 1,
  parameter int XLEN       = 32
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                         issue_valid;
  logic [NW_WIDTH-1:0]          issue_wid;
  logic [NUM_BLOCKS-1:0]        br_valid;
  logic [NUM_BLOCKS*NW_WIDTH-1:0] br_wid;
  logic [NUM_BLOCKS-1:0]        br_taken;
  logic [NUM_BLOCKS*XLEN-1:0]   br_dest;
  logic                         redir_valid;
  logic [NW_WIDTH-1:0]          redir_wid;
  logic                         redir_taken;
  logic [XLEN-1:0]              redir_dest;
  logic                         redir_ready;
  logic [NUM_WARPS-1:0]         stalled;
  logic                         err;

  modport slave (
    input  issue_valid, issue_wid, br_valid, br_wid, br_taken, br_dest,
    input  redir_ready,
    output redir_valid, redir_wid, redir_taken, redir_dest, stalled, err
  );

  modport master (
    output issue_valid, issue_wid, br_valid, br_wid, br_taken, br_dest,
    output redir_ready,
    input  redir_valid, redir_wid, redir_taken, redir_dest, stalled, err
  );
endinterface

// File: rtl/vx_branch_resolve.sv
// vx_branch_resolve
//   Per-warp branch tracker. A warp goes IDLE -> WAIT on branch issue,
//   WAIT -> READY when any ALU block resolves it (capturing taken/dest),
//   and READY -> IDLE when its redirect is accepted by the scheduler.
//   One redirect is presented per cycle, chosen round-robin among READY
//   warps starting at the RR pointer.
//   Ports:
//   - clk   : clock, rising edge
//   - reset : asynchronous, active-low reset
//   - bus   : vx_branch_resolve_if.slave (issue, resolution, redirect,
//             stalled, err)
module vx_branch_resolve #(
  parameter int NUM_WARPS  = 4,
  parameter int NUM_BLOCKS = 1,
  parameter int XLEN       = 32
) (
  input  logic                clk,
  input  logic                reset,
  vx_branch_resolve_if.slave  bus
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam logic [NW_WIDTH-1:0] LAST_WID = NW_WIDTH'(NUM_WARPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e              state_q [NUM_WARPS];
  state_e              state_d [NUM_WARPS];
  logic                taken_q [NUM_WARPS];
  logic                taken_d [NUM_WARPS];
  logic [XLEN-1:0]     dest_q  [NUM_WARPS];
  logic [XLEN-1:0]     dest_d  [NUM_WARPS];
  logic [NW_WIDTH-1:0] rr_q, rr_d;
  logic                err_q, err_d;

  logic                any_ready;
  logic [NW_WIDTH-1:0] grant;
  logic                hs;
  logic [NW_WIDTH-1:0] res_wid;
  logic [NUM_WARPS-1:0] claimed;

  // Warp index (base + off) modulo NUM_WARPS; off is always < NUM_WARPS.
  function automatic logic [NW_WIDTH-1:0] wrap_idx(input logic [NW_WIDTH-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_WARPS) s = s - NUM_WARPS;
    return NW_WIDTH'(s);
  endfunction

  // Round-robin grant: first READY warp at or after the pointer.
  always_comb begin
    any_ready = 1'b0;
    grant     = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!any_ready && state_q[wrap_idx(rr_q, i)] == ST_READY) begin
        any_ready = 1'b1;
        grant     = wrap_idx(rr_q, i);
      end
    end
  end

  assign hs = any_ready && bus.redir_ready;

  // Outputs depend only on registered state, so they stay stable until a
  // handshake and never combinationally follow the inputs.
  assign bus.redir_valid = any_ready;
  assign bus.redir_wid   = any_ready ? grant : '0;
  assign bus.redir_taken = any_ready & taken_q[grant];
  assign bus.redir_dest  = any_ready ? dest_q[grant] : '0;
  assign bus.err         = err_q;

  always_comb begin
    bus.stalled = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      bus.stalled[i] = (state_q[i] != ST_IDLE);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      state_d[i] = state_q[i];
      taken_d[i] = taken_q[i];
      dest_d[i]  = dest_q[i];
    end
    rr_d    = rr_q;
    err_d   = err_q;
    claimed = '0;
    res_wid = '0;

    if (hs) begin
      state_d[grant] = ST_IDLE;
      rr_d = (grant == LAST_WID) ? '0 : grant + NW_WIDTH'(1);
    end

    // Issue. A READY warp draining this very cycle may take a new branch;
    // the later assignment overrides the IDLE written by the handshake.
    if (bus.issue_valid) begin
      if (int'(bus.issue_wid) >= NUM_WARPS) begin
        err_d = 1'b1;
      end else if (state_q[bus.issue_wid] == ST_IDLE) begin
        state_d[bus.issue_wid] = ST_WAIT;
      end else if (state_q[bus.issue_wid] == ST_READY && hs && grant == bus.issue_wid) begin
        state_d[bus.issue_wid] = ST_WAIT;
      end else begin
        err_d = 1'b1;
      end
    end

    // Resolution. Only a warp already WAIT in registered state accepts it,
    // so an issue+resolve of an IDLE warp in one cycle leaves it WAIT and
    // flags the resolution. 'claimed' makes the lowest block win a collision.
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      if (bus.br_valid[b]) begin
        res_wid = bus.br_wid[b*NW_WIDTH +: NW_WIDTH];
        if (int'(res_wid) >= NUM_WARPS) begin
          err_d = 1'b1;
        end else if (claimed[res_wid]) begin
          err_d = 1'b1;
        end else begin
          claimed[res_wid] = 1'b1;
          if (state_q[res_wid] == ST_WAIT) begin
            state_d[res_wid] = ST_READY;
            taken_d[res_wid] = bus.br_taken[b];
            dest_d[res_wid]  = bus.br_dest[b*XLEN +: XLEN];
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= ST_IDLE;
        taken_q[i] <= 1'b0;
        dest_q[i]  <= '0;
      end
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= state_d[i];
        taken_q[i] <= taken_d[i];
        dest_q[i]  <= dest_d[i];
      end
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_vx_branch_resolve.sv
// tb_vx_branch_resolve
//   Directed bench for vx_branch_resolve (NUM_WARPS=4, NUM_BLOCKS=2, XLEN=32).
module tb_vx_branch_resolve;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errs;
  logic [31:0] exp_dest [4];
  int   prev;

  vx_branch_resolve_if #(.NUM_WARPS(4), .NUM_BLOCKS(2), .XLEN(32)) bus ();

  vx_branch_resolve #(.NUM_WARPS(4), .NUM_BLOCKS(2), .XLEN(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.issue_valid = 1'b0;
    bus.issue_wid   = '0;
    bus.br_valid    = '0;
    bus.br_wid      = '0;
    bus.br_taken    = '0;
    bus.br_dest     = '0;
  endtask

  task automatic issue(input int w);
    bus.issue_valid = 1'b1;
    bus.issue_wid   = 2'(w);
  endtask

  task automatic res(input int b, input int w, input logic t, input logic [31:0] d);
    logic [1:0] w2;
    w2 = 2'(w);
    bus.br_valid[b]         = 1'b1;
    bus.br_wid[b*2 +: 2]    = w2;
    bus.br_taken[b]         = t;
    bus.br_dest[b*32 +: 32] = d;
  endtask

  task automatic do_reset();
    clr_in();
    bus.redir_ready = 1'b0;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    clr_in();
    bus.redir_ready = 1'b0;
    reset = 1'b0;

    // Reset state
    #12;
    chk("rst_stalled", bus.stalled, 4'b0000);
    chk("rst_rvalid", bus.redir_valid, 0);
    chk("rst_rwid", bus.redir_wid, 0);
    chk("rst_rdest", bus.redir_dest, 0);
    chk("rst_err", bus.err, 0);
    reset = 1'b1;
    step();
    chk("idle_stalled", bus.stalled, 4'b0000);
    chk("idle_rvalid", bus.redir_valid, 0);

    // Single branch: issue wid2 at t0, resolve at t3, redirect at t4
    issue(2);
    step();                                    // t1
    clr_in();
    chk("t1_stalled", bus.stalled, 4'b0100);
    chk("t1_rvalid", bus.redir_valid, 0);
    step();                                    // t2
    step();                                    // t3
    chk("t3_rvalid", bus.redir_valid, 0);
    res(0, 2, 1'b1, 32'h8000_1000);
    step();                                    // t4
    clr_in();
    chk("t4_rvalid", bus.redir_valid, 1);
    chk("t4_rwid", bus.redir_wid, 2);
    chk("t4_rtaken", bus.redir_taken, 1);
    chk("t4_rdest", bus.redir_dest, 32'h8000_1000);
    chk("t4_stalled", bus.stalled, 4'b0100);
    bus.redir_ready = 1'b1;
    step();                                    // t5
    bus.redir_ready = 1'b0;
    chk("t5_stalled", bus.stalled, 4'b0000);
    chk("t5_rvalid", bus.redir_valid, 0);
    chk("t5_rdest", bus.redir_dest, 0);
    chk("t5_err", bus.err, 0);

    // Two blocks resolving two warps in one cycle, back-pressure held
    do_reset();
    issue(1);
    step();
    issue(3);
    step();
    clr_in();
    res(0, 1, 1'b1, 32'h100);
    res(1, 3, 1'b0, 32'h200);
    step();
    clr_in();
    for (int i = 0; i < 2; i++) begin
      chk("hold_rwid", bus.redir_wid, 1);
      chk("hold_rdest", bus.redir_dest, 32'h100);
      chk("hold_rtaken", bus.redir_taken, 1);
      chk("hold_stalled", bus.stalled, 4'b1010);
      step();
    end
    bus.redir_ready = 1'b1;
    chk("dual_first_wid", bus.redir_wid, 1);
    step();
    chk("dual_second_wid", bus.redir_wid, 3);
    chk("dual_second_dest", bus.redir_dest, 32'h200);
    chk("dual_second_taken", bus.redir_taken, 0);
    chk("dual_mid_stalled", bus.stalled, 4'b1000);
    step();
    bus.redir_ready = 1'b0;
    chk("dual_done_rvalid", bus.redir_valid, 0);
    chk("dual_done_stalled", bus.stalled, 4'b0000);
    chk("dual_err", bus.err, 0);

    // Round-robin with immediate re-issue / re-resolve of each drained warp
    do_reset();
    for (int w = 0; w < 4; w++) begin
      issue(w);
      step();
    end
    clr_in();
    res(0, 0, 1'b0, 32'h1000);
    res(1, 1, 1'b1, 32'h1001);
    step();
    clr_in();
    res(0, 2, 1'b0, 32'h1002);
    res(1, 3, 1'b1, 32'h1003);
    step();
    clr_in();
    for (int w = 0; w < 4; w++) exp_dest[w] = 32'h1000 + 32'(w);
    chk("rr_all_stalled", bus.stalled, 4'b1111);
    bus.redir_ready = 1'b1;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_rvalid", bus.redir_valid, 1);
      chk("rr_rwid", bus.redir_wid, 64'(k % 4));
      chk("rr_rdest", bus.redir_dest, exp_dest[k % 4]);
      clr_in();
      issue(k % 4);
      if (prev >= 0) begin
        res(0, prev, 1'b1, 32'h3000 + 32'(k));
        exp_dest[prev] = 32'h3000 + 32'(k);
      end
      prev = k % 4;
      step();
    end
    clr_in();
    bus.redir_ready = 1'b0;
    chk("rr_err", bus.err, 0);

    // Protocol violations
    do_reset();
    res(0, 0, 1'b1, 32'hDEAD);
    step();
    clr_in();
    chk("viol_idle_err", bus.err, 1);
    chk("viol_idle_rvalid", bus.redir_valid, 0);
    chk("viol_idle_stalled", bus.stalled, 4'b0000);
    issue(1);
    step();
    chk("viol_w1_stalled", bus.stalled, 4'b0010);
    step();                                    // second issue to WAIT warp 1
    clr_in();
    chk("viol_wait_err", bus.err, 1);
    chk("viol_wait_stalled", bus.stalled, 4'b0010);
    chk("viol_wait_rvalid", bus.redir_valid, 0);
    res(0, 1, 1'b0, 32'hA);
    res(1, 1, 1'b1, 32'hB);
    step();
    clr_in();
    chk("collide_rvalid", bus.redir_valid, 1);
    chk("collide_rdest", bus.redir_dest, 32'hA);
    chk("collide_rtaken", bus.redir_taken, 0);
    chk("collide_err", bus.err, 1);

    // Asynchronous reset with warps 0 and 2 READY
    do_reset();
    chk("err_cleared", bus.err, 0);
    issue(0);
    step();
    issue(2);
    step();
    clr_in();
    res(0, 0, 1'b1, 32'h44);
    res(1, 2, 1'b1, 32'h88);
    step();
    clr_in();
    chk("pre_arst_rvalid", bus.redir_valid, 1);
    chk("pre_arst_stalled", bus.stalled, 4'b0101);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rvalid", bus.redir_valid, 0);
    chk("arst_stalled", bus.stalled, 4'b0000);
    chk("arst_rdest", bus.redir_dest, 0);
    #3;
    reset = 1'b1;
    step();
    chk("post_arst_rvalid", bus.redir_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
